alu_input_sequencer: RTL and testbench
======================================

ALU_INPUT_SEQUENCER -- requirements
Module: alu_input_sequencer

Interface
REQ-001 Parameter N_BITS, default 8, operand and result width.
REQ-002 Parameter NB_OP, default 6, opcode width.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, stable-level cycles required to accept a button edge (minimum 1).
REQ-004 Parameter ALU_LATENCY, default 1, cycles from operand presentation to a valid i_alu_result (minimum 1).
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port clock  input  1  rising-edge clock.
REQ-007 Port i_sw  input  N_BITS  switch value captured on each accepted load press.
REQ-008 Port i_btn_load  input  1  raw, asynchronous load pushbutton.
REQ-009 Port i_btn_clear  input  1  raw, asynchronous clear pushbutton.
REQ-010 Port o_alu_a  output  N_BITS  registered operand A to ALU.
REQ-011 Port o_alu_b  output  N_BITS  registered operand B to ALU.
REQ-012 Port o_alu_op  output  NB_OP  registered opcode to ALU.
REQ-013 Port i_alu_result  input  N_BITS  ALU result.
REQ-014 Port o_result  output  N_BITS  captured result, drives LEDs.
REQ-015 Port o_result_valid  output  1  high while o_result holds a fresh result.
REQ-016 Port o_state  output  3  current FSM state encoding, for status LEDs.
REQ-017 Port o_err  output  1  sticky illegal-opcode flag.

Function
REQ-018 Each button SHALL pass a 2-flop synchronizer, then a debouncer; a press is accepted as a one-cycle pulse after the synchronized level is high for DEBOUNCE_CYCLES consecutive cycles.
REQ-019 A new press SHALL NOT be accepted until the synchronized level has been low for DEBOUNCE_CYCLES consecutive cycles; holding a button yields exactly one pulse.
REQ-020 FSM states and encodings: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, SHOW=4; o_state SHALL equal the current encoding.
REQ-021 WAIT_A: load pulse captures i_sw into o_alu_a, next state WAIT_B.
REQ-022 WAIT_B: load pulse captures i_sw into o_alu_b, next state WAIT_OP.
REQ-023 WAIT_OP: load pulse checks i_sw[NB_OP-1:0] against legal set {100000,100010,100100,100101,100110,000011,000010,100111}.
REQ-024 Legal opcode: capture into o_alu_op, clear o_err, next state EXEC; illegal: o_alu_op unchanged, set o_err, remain WAIT_OP.
REQ-025 EXEC: wait counter SHALL count ALU_LATENCY cycles, then capture i_alu_result into o_result, set o_result_valid, next state SHOW; load pulses in EXEC SHALL be ignored.
REQ-026 SHOW: o_result and operands held; load pulse clears o_result_valid, next state WAIT_A; o_alu_a/b/op retain values until overwritten.
REQ-027 Clear pulse in any state SHALL next cycle force WAIT_A, zero o_alu_a, o_alu_b, o_alu_op, o_result, clear o_result_valid and o_err, reset the EXEC counter.
REQ-028 Clear and load pulses in the same cycle: clear SHALL win, load discarded.
REQ-029 Operands and o_result are unsigned N_BITS values; no width extension or truncation inside this block.

Reset
REQ-030 Reset SHALL asynchronously force WAIT_A, all outputs to 0, synchronizer and debounce counters to 0, debouncer release-armed (first press acceptable).
REQ-031 A press in progress at reset deassertion SHALL be accepted only after a full DEBOUNCE_CYCLES high window following reset.
REQ-032 Reset during EXEC SHALL abort the operation; o_result_valid stays 0.

Verification
REQ-033 Sequence sw=0x05 load, sw=0x03 load, sw=0x20 load, ALU model A+B -> o_result=0x08, o_result_valid=1, o_state=4, exactly ALU_LATENCY cycles after entering EXEC.
REQ-034 In WAIT_OP, sw=0x3F load -> o_err=1, o_state=2, o_alu_op unchanged; then sw=0x22 load -> o_err=0, EXEC, result A-B.
REQ-035 Load glitch high for DEBOUNCE_CYCLES-1 cycles -> no state change; button held 50 cycles -> exactly one advance.
REQ-036 Clear asserted in SHOW with o_result=0x08 -> next cycle o_state=0, all outputs 0; clear and load same cycle -> o_state=0, A not captured.
REQ-037 Reset asserted mid-EXEC between clock edges -> outputs 0 immediately, o_state=0, no result capture after release.

Source files
------------

// File: rtl/alu_input_sequencer.sv
// Front-panel sequencer for a combinational ALU: debounced buttons step through
// operand A, operand B and opcode entry, wait out the ALU latency and latch the result.
module alu_input_sequencer #(
  parameter int N_BITS          = 8,
  parameter int NB_OP           = 6,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ALU_LATENCY     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_sw,
  input  logic              i_btn_load,
  input  logic              i_btn_clear,
  output logic [N_BITS-1:0] o_alu_a,
  output logic [N_BITS-1:0] o_alu_b,
  output logic [NB_OP-1:0]  o_alu_op,
  input  logic [N_BITS-1:0] i_alu_result,
  output logic [N_BITS-1:0] o_result,
  output logic              o_result_valid,
  output logic [2:0]        o_state,
  output logic              o_err
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(ALU_LATENCY + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(ALU_LATENCY - 1);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_e;

  // Button index 0 is load, index 1 is clear.
  logic [1:0]         btn_raw;
  logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]         armed_q, armed_d;
  logic [1:0]         pulse_q, pulse_d;

  state_e              state_q, state_d;
  logic [N_BITS-1:0]   alu_a_q, alu_a_d;
  logic [N_BITS-1:0]   alu_b_q, alu_b_d;
  logic [NB_OP-1:0]    alu_op_q, alu_op_d;
  logic [N_BITS-1:0]   result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                err_q, err_d;
  logic [LW-1:0]       wait_cnt_q, wait_cnt_d;

  logic load_pulse, clear_pulse;

  assign btn_raw     = {i_btn_clear, i_btn_load};
  assign load_pulse  = pulse_q[0];
  assign clear_pulse = pulse_q[1];

  function automatic logic legal_op(input logic [NB_OP-1:0] op);
    case (op)
      NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100), NB_OP'(6'b100101),
      NB_OP'(6'b100110), NB_OP'(6'b000011), NB_OP'(6'b000010), NB_OP'(6'b100111):
        legal_op = 1'b1;
      default:
        legal_op = 1'b0;
    endcase
  endfunction

  // Armed debouncers wait for a stable high window and fire; disarmed ones wait
  // for a stable low window before re-arming, so a held button fires once.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      armed_d[i]  = armed_q[i];
      pulse_d[i]  = 1'b0;
      if (sync2_q[i] == armed_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          armed_d[i] = !armed_q[i];
          pulse_d[i] = armed_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    err_d          = err_q;
    wait_cnt_d     = wait_cnt_q;

    if (clear_pulse) begin
      state_d        = WAIT_A;
      alu_a_d        = '0;
      alu_b_d        = '0;
      alu_op_d       = '0;
      result_d       = '0;
      result_valid_d = 1'b0;
      err_d          = 1'b0;
      wait_cnt_d     = '0;
    end else begin
      case (state_q)
        WAIT_A: if (load_pulse) begin
          alu_a_d = i_sw;
          state_d = WAIT_B;
        end
        WAIT_B: if (load_pulse) begin
          alu_b_d = i_sw;
          state_d = WAIT_OP;
        end
        WAIT_OP: if (load_pulse) begin
          if (legal_op(i_sw[NB_OP-1:0])) begin
            alu_op_d   = i_sw[NB_OP-1:0];
            err_d      = 1'b0;
            wait_cnt_d = '0;
            state_d    = EXEC;
          end else begin
            err_d = 1'b1;
          end
        end
        EXEC: begin
          if (wait_cnt_q == LAT_LAST) begin
            result_d       = i_alu_result;
            result_valid_d = 1'b1;
            state_d        = SHOW;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        SHOW: if (load_pulse) begin
          result_valid_d = 1'b0;
          state_d        = WAIT_A;
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      db_cnt_q       <= '0;
      armed_q        <= '1;
      pulse_q        <= '0;
      state_q        <= WAIT_A;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      wait_cnt_q     <= '0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      db_cnt_q       <= db_cnt_d;
      armed_q        <= armed_d;
      pulse_q        <= pulse_d;
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  assign o_alu_a        = alu_a_q;
  assign o_alu_b        = alu_b_q;
  assign o_alu_op       = alu_op_q;
  assign o_result       = result_q;
  assign o_result_valid = result_valid_q;
  assign o_state        = state_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Self-checking bench for alu_input_sequencer: an external ALU model plus an
// operation-level reference of what each button press should leave on the outputs.
module tb_alu_input_sequencer;

  localparam int N_BITS = 8;
  localparam int NB_OP  = 6;
  localparam int DEB    = 4;
  localparam int LAT    = 1;
  localparam int HOLD   = DEB + 6;

  localparam logic [5:0] LEGAL [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N_BITS-1:0] i_sw = '0;
  logic              i_btn_load = 1'b0;
  logic              i_btn_clear = 1'b0;
  logic [N_BITS-1:0] o_alu_a, o_alu_b, o_result, i_alu_result;
  logic [NB_OP-1:0]  o_alu_op;
  logic              o_result_valid, o_err;
  logic [2:0]        o_state;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_op = '0;

  always #5 clock = ~clock;

  alu_input_sequencer #(
    .N_BITS(N_BITS), .NB_OP(NB_OP), .DEBOUNCE_CYCLES(DEB), .ALU_LATENCY(LAT)
  ) dut (
    .clock(clock), .reset(reset), .i_sw(i_sw),
    .i_btn_load(i_btn_load), .i_btn_clear(i_btn_clear),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .i_alu_result(i_alu_result), .o_result(o_result),
    .o_result_valid(o_result_valid), .o_state(o_state), .o_err(o_err)
  );

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      6'h20: alu_model = a + b;
      6'h22: alu_model = a - b;
      6'h24: alu_model = a & b;
      6'h25: alu_model = a | b;
      6'h26: alu_model = a ^ b;
      6'h03: alu_model = 8'($signed(a) >>> b[2:0]);
      6'h02: alu_model = a >> b[2:0];
      6'h27: alu_model = ~(a | b);
      default: alu_model = 8'h00;
    endcase
  endfunction

  assign i_alu_result = alu_model(o_alu_a, o_alu_b, o_alu_op);

  function automatic logic is_legal(input logic [5:0] op);
    is_legal = 1'b0;
    foreach (LEGAL[k]) if (LEGAL[k] == op) is_legal = 1'b1;
  endfunction

  // One complete press: hold long enough to fire, release long enough to re-arm.
  task automatic press(input logic ld, input logic cl, input logic [7:0] sw);
    i_sw = sw;
    i_btn_load = ld;
    i_btn_clear = cl;
    repeat (HOLD) @(negedge clock);
    i_btn_load = 1'b0;
    i_btn_clear = 1'b0;
    repeat (HOLD) @(negedge clock);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    checks++;
    if (o_state !== 3'd0) begin
      errors++; $display("FAIL reset_state got %0d want 0", o_state);
    end
    checks++;
    if ({o_alu_a, o_alu_b, o_alu_op, o_result, o_result_valid, o_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got a=%h b=%h op=%h r=%h v=%b e=%b want all 0",
               o_alu_a, o_alu_b, o_alu_op, o_result, o_result_valid, o_err);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_basic;
    int first_exec = -1;
    int first_show = -1;
    logic valid_in_exec = 1'b0;
    press(1'b1, 1'b0, 8'h05);
    press(1'b1, 1'b0, 8'h03);
    i_sw = 8'h20;
    i_btn_load = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (o_state == 3'd3 && first_exec < 0) begin
        first_exec = c;
        valid_in_exec = o_result_valid;
      end
      if (o_state == 3'd4 && first_show < 0) first_show = c;
    end
    i_btn_load = 1'b0;
    repeat (HOLD) @(negedge clock);
    exp_op = 6'h20;
    checks++;
    if (first_exec < 0 || first_show < 0) begin
      errors++; $display("FAIL basic_timeout exec_seen=%0d show_seen=%0d want both >=0", first_exec, first_show);
    end else if (first_show - first_exec != LAT) begin
      errors++; $display("FAIL basic_latency got %0d want %0d", first_show - first_exec, LAT);
    end
    checks++;
    if (valid_in_exec !== 1'b0) begin
      errors++; $display("FAIL basic_valid_in_exec got %b want 0", valid_in_exec);
    end
    checks++;
    if (o_result !== 8'h08 || o_result_valid !== 1'b1 || o_state !== 3'd4) begin
      errors++; $display("FAIL basic_result got r=%h v=%b st=%0d want r=08 v=1 st=4",
                         o_result, o_result_valid, o_state);
    end
    checks++;
    if (o_alu_op !== 6'h20 || o_err !== 1'b0) begin
      errors++; $display("FAIL basic_op got op=%h err=%b want op=20 err=0", o_alu_op, o_err);
    end
  endtask

  task automatic test_illegal;
    press(1'b1, 1'b0, 8'h00);  // leave SHOW
    checks++;
    if (o_state !== 3'd0 || o_result_valid !== 1'b0 || o_result !== 8'h08 || o_alu_a !== 8'h05) begin
      errors++; $display("FAIL show_exit got st=%0d v=%b r=%h a=%h want st=0 v=0 r=08 a=05",
                         o_state, o_result_valid, o_result, o_alu_a);
    end
    press(1'b1, 1'b0, 8'h05);
    press(1'b1, 1'b0, 8'h03);
    press(1'b1, 1'b0, 8'h3F);
    checks++;
    if (o_err !== 1'b1 || o_state !== 3'd2 || o_alu_op !== exp_op) begin
      errors++; $display("FAIL illegal_op got err=%b st=%0d op=%h want err=1 st=2 op=%h",
                         o_err, o_state, o_alu_op, exp_op);
    end
    press(1'b1, 1'b0, 8'h22);
    exp_op = 6'h22;
    checks++;
    if (o_err !== 1'b0 || o_state !== 3'd4 || o_alu_op !== 6'h22 || o_result !== 8'h02) begin
      errors++; $display("FAIL legal_after_illegal got err=%b st=%0d op=%h r=%h want err=0 st=4 op=22 r=02",
                         o_err, o_state, o_alu_op, o_result);
    end
  endtask

  task automatic test_debounce;
    i_btn_load = 1'b1;
    repeat (DEB - 1) @(negedge clock);
    i_btn_load = 1'b0;
    repeat (20) @(negedge clock);
    checks++;
    if (o_state !== 3'd4) begin
      errors++; $display("FAIL glitch got st=%0d want 4", o_state);
    end
    i_sw = 8'h11;
    i_btn_load = 1'b1;
    repeat (50) @(negedge clock);
    i_btn_load = 1'b0;
    repeat (HOLD) @(negedge clock);
    checks++;
    if (o_state !== 3'd0) begin
      errors++; $display("FAIL hold_show got st=%0d want 0", o_state);
    end
    i_btn_load = 1'b1;
    repeat (50) @(negedge clock);
    i_btn_load = 1'b0;
    repeat (HOLD) @(negedge clock);
    checks++;
    if (o_state !== 3'd1 || o_alu_a !== 8'h11) begin
      errors++; $display("FAIL hold_wait_a got st=%0d a=%h want st=1 a=11", o_state, o_alu_a);
    end
  endtask

  task automatic test_clear;
    logic seen = 1'b0;
    press(1'b0, 1'b1, 8'h00);
    exp_op = '0;
    press(1'b1, 1'b0, 8'h05);
    press(1'b1, 1'b0, 8'h03);
    press(1'b1, 1'b0, 8'h20);
    exp_op = 6'h20;
    checks++;
    if (o_state !== 3'd4 || o_result !== 8'h08) begin
      errors++; $display("FAIL clear_setup got st=%0d r=%h want st=4 r=08", o_state, o_result);
    end
    i_btn_clear = 1'b1;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clock);
      if (o_state !== 3'd4) begin
        seen = 1'b1;
        checks++;
        if (o_state !== 3'd0 ||
            {o_alu_a, o_alu_b, o_alu_op, o_result, o_result_valid, o_err} !== '0) begin
          errors++; $display("FAIL clear_show got st=%0d a=%h b=%h op=%h r=%h v=%b e=%b want all 0",
                             o_state, o_alu_a, o_alu_b, o_alu_op, o_result, o_result_valid, o_err);
        end
      end
    end
    if (!seen) begin
      checks++; errors++; $display("FAIL clear_timeout got st=%0d want 0", o_state);
    end
    i_btn_clear = 1'b0;
    repeat (HOLD) @(negedge clock);
    exp_op = '0;
    press(1'b1, 1'b1, 8'h5A);
    checks++;
    if (o_state !== 3'd0 || o_alu_a !== 8'h00) begin
      errors++; $display("FAIL clear_and_load got st=%0d a=%h want st=0 a=00", o_state, o_alu_a);
    end
    press(1'b1, 1'b0, 8'h05);
    press(1'b1, 1'b0, 8'h03);
    press(1'b1, 1'b0, 8'h3F);
    press(1'b0, 1'b1, 8'h00);
    checks++;
    if (o_state !== 3'd0 || o_err !== 1'b0 || o_alu_a !== 8'h00) begin
      errors++; $display("FAIL clear_err got st=%0d err=%b a=%h want st=0 err=0 a=00", o_state, o_err, o_alu_a);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 16; it++) begin
      logic [7:0] a, b;
      logic [5:0] op, bad;
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = LEGAL[$urandom_range(0, 7)];
      press(1'b1, 1'b0, a);
      press(1'b1, 1'b0, b);
      if ($urandom_range(0, 1) == 1) begin
        do bad = 6'($urandom); while (is_legal(bad));
        press(1'b1, 1'b0, {2'b11, bad});
        checks++;
        if (o_err !== 1'b1 || o_state !== 3'd2 || o_alu_op !== exp_op) begin
          errors++; $display("FAIL rand_illegal it=%0d op=%h got err=%b st=%0d aluop=%h want err=1 st=2 aluop=%h",
                             it, bad, o_err, o_state, o_alu_op, exp_op);
        end
      end
      press(1'b1, 1'b0, {2'b00, op});
      exp_op = op;
      checks++;
      if (o_state !== 3'd4 || o_result_valid !== 1'b1 || o_err !== 1'b0 ||
          o_alu_a !== a || o_alu_b !== b || o_alu_op !== op || o_result !== alu_model(a, b, op)) begin
        errors++; $display("FAIL rand_exec it=%0d got st=%0d v=%b e=%b a=%h b=%h op=%h r=%h want st=4 v=1 e=0 a=%h b=%h op=%h r=%h",
                           it, o_state, o_result_valid, o_err, o_alu_a, o_alu_b, o_alu_op, o_result,
                           a, b, op, alu_model(a, b, op));
      end
      press(1'b1, 1'b0, 8'h00);
      checks++;
      if (o_state !== 3'd0 || o_result_valid !== 1'b0 || o_alu_a !== a) begin
        errors++; $display("FAIL rand_return it=%0d got st=%0d v=%b a=%h want st=0 v=0 a=%h",
                           it, o_state, o_result_valid, o_alu_a, a);
      end
    end
  endtask

  task automatic test_reset_exec;
    logic seen = 1'b0;
    int   adv = -1;
    logic captured = 1'b0;
    press(1'b1, 1'b0, 8'h05);
    press(1'b1, 1'b0, 8'h03);
    i_sw = 8'h20;
    i_btn_load = 1'b1;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clock);
      if (o_state == 3'd3) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL reset_exec_timeout got st=%0d want 3", o_state);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (o_state !== 3'd0 ||
        {o_alu_a, o_alu_b, o_alu_op, o_result, o_result_valid, o_err} !== '0) begin
      errors++; $display("FAIL reset_exec_async got st=%0d a=%h b=%h op=%h r=%h v=%b e=%b want all 0",
                         o_state, o_alu_a, o_alu_b, o_alu_op, o_result, o_result_valid, o_err);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    // Button still held across release: it must need a full fresh window.
    for (int c = 1; c <= 40 && adv < 0; c++) begin
      @(negedge clock);
      if (o_result_valid !== 1'b0 || o_result !== 8'h00) captured = 1'b1;
      if (o_state !== 3'd0) adv = c;
    end
    i_btn_load = 1'b0;
    repeat (HOLD) @(negedge clock);
    checks++;
    if (adv < DEB + 2) begin
      errors++; $display("FAIL reset_press_window got %0d cycles want >= %0d", adv, DEB + 2);
    end
    checks++;
    if (captured || o_result_valid !== 1'b0 || o_result !== 8'h00 || o_state !== 3'd1) begin
      errors++; $display("FAIL reset_exec_no_capture got cap=%b v=%b r=%h st=%0d want cap=0 v=0 r=00 st=1",
                         captured, o_result_valid, o_result, o_state);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_debounce();
    test_clear();
    test_random();
    test_reset_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
